// File: rtl/pipe_pkg.sv
// Shared game constants: state encoding, LFSR taps, default screen geometry.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: none; consumers are free-running frame-tick logic.
package pipe_pkg;

   // Game state encoding shared by every block that follows the game flow.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } game_state_t;

   // Fibonacci tap positions (1-based bit numbers of a 32-bit register).
   localparam int LFSR_TAP_A = 32;
   localparam int LFSR_TAP_B = 22;
   localparam int LFSR_TAP_C = 2;
   localparam int LFSR_TAP_D = 1;

   // Default screen geometry.
   localparam int SCREEN_W     = 1023;
   localparam int SCREEN_Y_MIN = 300;
   localparam int SCREEN_Y_MAX = 560;

   // One shift of the 32-bit Fibonacci LFSR; feedback enters at bit 0.
   function automatic logic [31:0] lfsr_next(input logic [31:0] q);
      logic fb;
      fb = q[LFSR_TAP_A-1] ^ q[LFSR_TAP_B-1] ^ q[LFSR_TAP_C-1] ^ q[LFSR_TAP_D-1];
      return {q[30:0], fb};
   endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit free-running Fibonacci LFSR, loaded with seed while reset is held.
// Latency: new value every clk cycle; q is registered.
// Backpressure: none; always advances.
module lfsr32
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        RESET_GAME,
   input  logic [31:0] seed,
   output logic [31:0] q
);

   // Shift once per clock; reset reloads the (non-zero) seed.
   always_ff @(posedge clk or posedge RESET_GAME) begin
      if (RESET_GAME) begin
         q <= seed;
      end else begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/pipe_field_generator.sv
// Scrolls NUM_PIPES obstacle pipes right-to-left under a game FSM, with score.
// Latency: pipe_x/pipe_y/score update 1 cycle after move; pass_pulse 1 cycle after move.
// Backpressure: none; move/start are single-cycle ticks, collide freezes the field.
module pipe_field_generator
   import pipe_pkg::*;
#(
   parameter int          NUM_PIPES = 3,
   parameter int          X_W       = 11,
   parameter int          Y_W       = 11,
   parameter int          X_START   = 723,
   parameter int          SPACING   = 350,
   parameter int          X_RESPAWN = SCREEN_W,
   parameter int          Y_INIT    = 420,
   parameter int          Y_MIN     = SCREEN_Y_MIN,
   parameter int          RAND_BITS = 8,
   parameter int          BIRD_X    = 200,
   parameter int          SCORE_W   = 10,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
)(
   input  logic                     clk,
   input  logic                     RESET_GAME,
   input  logic                     move,
   input  logic                     start,
   input  logic                     collide,
   input  logic [3:0]               step,
   output logic [NUM_PIPES*X_W-1:0] pipe_x,
   output logic [NUM_PIPES*Y_W-1:0] pipe_y,
   output logic                     running,
   output logic                     pass_pulse,
   output logic [SCORE_W-1:0]       score
);

   localparam int                 CNT_W     = 3;
   localparam int                 SUM_W     = SCORE_W + CNT_W;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   game_state_t          state_q, state_d;
   logic                 reload;
   logic                 advance;
   logic [31:0]          lfsr_q;
   logic [NUM_PIPES-1:0] pass_vec;
   logic [X_W-1:0]       step_x;
   logic [CNT_W-1:0]     pass_cnt;
   logic [SUM_W-1:0]     score_sum;
   logic [SCORE_W-1:0]   score_d;

   assign step_x  = X_W'(step);
   assign running = (state_q == RUN);

   lfsr32 u_lfsr (
      .clk        (clk),
      .RESET_GAME (RESET_GAME),
      .seed       (LFSR_SEED),
      .q          (lfsr_q)
   );

   // Game state register.
   always_ff @(posedge clk or posedge RESET_GAME) begin
      if (RESET_GAME) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus field controls; collide beats move, IDLE ignores move.
   always_comb begin
      state_d = state_q;
      reload  = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (collide)   state_d = FROZEN;
            else if (move) advance = 1'b1;
         end
         FROZEN: begin
            if (start) begin
               reload  = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
      localparam logic [X_W-1:0] X_INIT = X_W'(X_START + g * SPACING);

      logic [X_W-1:0] x_q;
      logic [Y_W-1:0] y_q;
      logic [X_W-1:0] x_sub;
      logic           respawn;

      // A pipe that would go past the left edge respawns instead; that is never a pass.
      assign respawn     = (x_q < step_x);
      assign x_sub       = x_q - step_x;
      assign pass_vec[g] = advance && !respawn &&
                           (x_q >= X_W'(BIRD_X)) && (x_sub < X_W'(BIRD_X));

      // Per-pipe position: hold, reload on restart, or scroll/respawn on a run move.
      always_ff @(posedge clk or posedge RESET_GAME) begin
         if (RESET_GAME) begin
            x_q <= X_INIT;
            y_q <= Y_W'(Y_INIT);
         end else if (reload) begin
            x_q <= X_INIT;
            y_q <= Y_W'(Y_INIT);
         end else if (advance) begin
            if (respawn) begin
               x_q <= X_W'(X_RESPAWN);
               y_q <= Y_W'(Y_MIN) + Y_W'(lfsr_q[g*RAND_BITS +: RAND_BITS]);
            end else begin
               x_q <= x_sub;
            end
         end
      end

      assign pipe_x[g*X_W +: X_W] = x_q;
      assign pipe_y[g*Y_W +: Y_W] = y_q;
   end

   // Count pipes crossing the bird column this move and saturate the score.
   always_comb begin
      pass_cnt = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         pass_cnt = pass_cnt + CNT_W'(pass_vec[i]);
      end
      score_sum = SUM_W'(score) + SUM_W'(pass_cnt);
      score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
   end

   // Score and pass pulse registers; restart clears the score.
   always_ff @(posedge clk or posedge RESET_GAME) begin
      if (RESET_GAME) begin
         score      <= '0;
         pass_pulse <= 1'b0;
      end else begin
         pass_pulse <= |pass_vec;
         if (reload)       score <= '0;
         else if (advance) score <= score_d;
      end
   end

endmodule
